// File: rtl/uart_msg_serializer_pkg.sv
// Shared types and defaults for the UART message serializer: FSM encoding,
// default word width and default terminator value.
package uart_msg_serializer_pkg;

  localparam int         DEF_N         = 8;
  localparam logic [7:0] DEF_TERM_WORD = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/uart_msg_serializer_shift_reg.sv
// Message snapshot register: loads the whole message, shifts one word per step
// and presents the next word to send at its head, in the selected order.
module msg_shift_reg #(
  parameter int N         = 8,
  parameter int BYTES     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [N*BYTES-1:0] i_data,
  output logic [N-1:0]       o_head
);

  localparam int M = N * BYTES;

  logic [M-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= MSB_FIRST ? (r_data << N) : (r_data >> N);
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign o_head = r_data[M-1 -: N];
    end else begin : g_lsb
      assign o_head = r_data[N-1:0];
    end
  endgenerate

endmodule

// File: rtl/uart_msg_serializer.sv
// Feeds a multi-word message to uart_tx one word per enable/busy handshake,
// optionally followed by a terminator word, with ready/done status.
module uart_msg_serializer
  import uart_msg_serializer_pkg::*;
#(
  parameter int           N         = DEF_N,
  parameter int           BYTES     = 2,
  parameter bit           MSB_FIRST = 1'b1,
  parameter bit           TERM_EN   = 1'b0,
  parameter logic [N-1:0] TERM_WORD = N'(DEF_TERM_WORD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N*BYTES-1:0] data,
  input  logic               busy,
  output logic               enable,
  output logic [N-1:0]       bus,
  output logic               ready,
  output logic               done,
  output logic [2:0]         dbg_state
);

  localparam int            CW   = $clog2(BYTES + 2);
  localparam logic [CW-1:0] LAST = CW'(TERM_EN ? BYTES : BYTES - 1);
  localparam logic [CW-1:0] TCNT = CW'(BYTES);

  state_e        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_enable, r_ready, r_done;
  logic [N-1:0]  r_bus;
  logic          w_load, w_shift, w_enable_d, w_ready_d, w_done_d;
  logic [N-1:0]  w_head, w_word, w_bus_d;

  msg_shift_reg #(
    .N        (N),
    .BYTES    (BYTES),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_data (data),
    .o_head (w_head)
  );

  // Past the data words the counter selects the terminator.
  assign w_word = (TERM_EN && (r_cnt == TCNT)) ? TERM_WORD : w_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = ST_ISSUE;
      ST_ISSUE:     if (!busy) w_next = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (busy)  w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!busy) w_next = (r_cnt == LAST) ? ST_DONE : ST_ISSUE;
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the bus holds its word until busy falls.
  always_comb begin
    w_load     = (r_state == ST_IDLE) && start;
    w_shift    = (r_state == ST_WAIT_DONE) && !busy;
    w_enable_d = (r_state == ST_ISSUE) && !busy;
    w_ready_d  = (w_next == ST_IDLE);
    w_done_d   = (r_state == ST_WAIT_DONE) && (w_next == ST_DONE);
    w_bus_d    = '0;
    if (w_enable_d) begin
      w_bus_d = w_word;
    end else if ((w_next == ST_WAIT_ACK) || (w_next == ST_WAIT_DONE)) begin
      w_bus_d = r_bus;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable <= 1'b0;
      r_bus    <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_enable <= w_enable_d;
      r_bus    <= w_bus_d;
      r_ready  <= w_ready_d;
      r_done   <= w_done_d;
      if (w_load) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign enable    = r_enable;
  assign bus       = r_bus;
  assign ready     = r_ready;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
